// File: rtl/acs_sequencer.sv
// acs_sequencer: sweeps ACS segments per accepted code symbol; `ACS_SEQ_HOLD_EN adds a Hold stall input
module acs_sequencer #(
  parameter int WD_FSM  = 6,
  parameter int N_SEG   = 64,
  parameter int WD_CODE = 2,
  parameter int WD_CNT  = 8
) (
  input  logic               Clock2,
  input  logic               Reset,
`ifdef ACS_SEQ_HOLD_EN
  input  logic               Hold,
`endif
  input  logic [WD_CODE-1:0] Code,
  input  logic               CodeValid,
  output logic               CodeReady,
  output logic [WD_CODE-1:0] CodeRegister,
  output logic [WD_FSM-1:0]  ACSSegment,
  output logic               ACSEnable,
  output logic               SegFirst,
  output logic               SegLast,
  output logic               SymbolDone,
  output logic [WD_CNT-1:0]  SymbolCount
);
  typedef enum logic [1:0] {IDLE, SWEEP, FLUSH} state_t;
  localparam logic [WD_FSM-1:0] LAST = WD_FSM'(N_SEG - 1);
  state_t state, state_nxt;
  logic [WD_CODE-1:0] code_nxt;
  logic [WD_FSM-1:0] seg_nxt, seg_inc;
  logic [WD_CNT-1:0] cnt_nxt;
  logic en_nxt, first_nxt, last_nxt, done_nxt, ready_nxt, hold;
`ifdef ACS_SEQ_HOLD_EN
  assign hold = Hold;
`else
  assign hold = 1'b0;
`endif
  assign seg_inc = ACSSegment + WD_FSM'(1);
  always_comb begin
    state_nxt = state;
    code_nxt  = CodeRegister;
    seg_nxt   = ACSSegment;
    en_nxt    = ACSEnable;
    first_nxt = SegFirst;
    last_nxt  = SegLast;
    done_nxt  = SymbolDone;
    ready_nxt = CodeReady;
    cnt_nxt   = SymbolCount;
    case (state)
      IDLE: begin
        // CodeReady is only low in IDLE on the first edge out of reset
        if (!CodeReady) ready_nxt = 1'b1;
        else if (CodeValid) begin
          code_nxt  = Code;
          seg_nxt   = '0;
          en_nxt    = 1'b1;
          first_nxt = 1'b1;
          last_nxt  = (LAST == '0);
          ready_nxt = 1'b0;
          state_nxt = SWEEP;
        end
      end
      SWEEP: begin
        first_nxt = 1'b0;
        if (hold) begin
          en_nxt   = 1'b0;
          last_nxt = 1'b0;
        end else if (ACSSegment == LAST) begin
          seg_nxt   = '1;
          en_nxt    = 1'b0;
          last_nxt  = 1'b0;
          done_nxt  = 1'b1;
          cnt_nxt   = SymbolCount + WD_CNT'(1);
          state_nxt = FLUSH;
        end else begin
          seg_nxt  = seg_inc;
          en_nxt   = 1'b1;
          last_nxt = (seg_inc == LAST);
        end
      end
      FLUSH: begin
        done_nxt  = 1'b0;
        ready_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clock2 or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      CodeRegister <= '0;
      ACSSegment   <= '1;
      ACSEnable    <= 1'b0;
      SegFirst     <= 1'b0;
      SegLast      <= 1'b0;
      SymbolDone   <= 1'b0;
      CodeReady    <= 1'b0;
      SymbolCount  <= '0;
    end else begin
      state        <= state_nxt;
      CodeRegister <= code_nxt;
      ACSSegment   <= seg_nxt;
      ACSEnable    <= en_nxt;
      SegFirst     <= first_nxt;
      SegLast      <= last_nxt;
      SymbolDone   <= done_nxt;
      CodeReady    <= ready_nxt;
      SymbolCount  <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_acs_sequencer.sv
// tb_acs_sequencer: directed checks of acs_sequencer (Hold case only with ACS_SEQ_HOLD_EN)
module tb_acs_sequencer;
  logic Clock2 = 1'b0, Reset = 1'b1, CodeValid = 1'b0, Hold = 1'b0;
  logic [1:0] Code = '0, CodeRegister;
  logic [5:0] ACSSegment;
  logic [7:0] SymbolCount;
  logic CodeReady, ACSEnable, SegFirst, SegLast, SymbolDone;
  int n_chk = 0, n_bad = 0, cyc = 0, last_acc;
  acs_sequencer dut (
    .Clock2(Clock2), .Reset(Reset),
`ifdef ACS_SEQ_HOLD_EN
    .Hold(Hold),
`endif
    .Code(Code), .CodeValid(CodeValid), .CodeReady(CodeReady),
    .CodeRegister(CodeRegister), .ACSSegment(ACSSegment), .ACSEnable(ACSEnable),
    .SegFirst(SegFirst), .SegLast(SegLast), .SymbolDone(SymbolDone), .SymbolCount(SymbolCount)
  );
  always #5 Clock2 = ~Clock2;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask
  task automatic step;
    @(posedge Clock2);
    #1;
    cyc++;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seg"}, ACSSegment, 6'h3f);
    chk({tag, "_creg"}, CodeRegister, 0);
    chk({tag, "_en"}, ACSEnable, 0);
    chk({tag, "_first"}, SegFirst, 0);
    chk({tag, "_last"}, SegLast, 0);
    chk({tag, "_done"}, SymbolDone, 0);
    chk({tag, "_rdy"}, CodeReady, 0);
    chk({tag, "_cnt"}, SymbolCount, 0);
  endtask
  // called in the cycle showing segment 0; returns in the cycle CodeReady is back
  task automatic sweep_check(input logic [1:0] c, input int cnt, input bit tog);
    logic sv_v;
    logic [1:0] sv_c;
    sv_v = CodeValid;
    sv_c = Code;
    for (int i = 0; i < 64; i++) begin
      chk("sw_seg", ACSSegment, i);
      chk("sw_en", ACSEnable, 1);
      chk("sw_first", SegFirst, i == 0);
      chk("sw_last", SegLast, i == 63);
      chk("sw_creg", CodeRegister, c);
      chk("sw_rdy", CodeReady, 0);
      chk("sw_done", SymbolDone, 0);
      if (tog) begin
        Code = 2'(i);
        CodeValid = i[0];
      end
      step;
    end
    CodeValid = sv_v;
    Code = sv_c;
    chk("fl_done", SymbolDone, 1);
    chk("fl_en", ACSEnable, 0);
    chk("fl_seg", ACSSegment, 6'h3f);
    chk("fl_last", SegLast, 0);
    chk("fl_cnt", SymbolCount, cnt);
    chk("fl_rdy", CodeReady, 0);
    chk("fl_creg", CodeRegister, c);
    step;
    chk("id_done", SymbolDone, 0);
    chk("id_rdy", CodeReady, 1);
    chk("id_en", ACSEnable, 0);
  endtask
  initial begin
    step;
    step;
    chk_reset_vals("rst");
    CodeValid = 1'b1;
    Code = 2'b11;
    Reset = 1'b0;
    step;
    chk("rel_rdy", CodeReady, 1);
    chk("rel_en", ACSEnable, 0);
    chk("rel_creg", CodeRegister, 0);
    step;
    chk("acc_creg", CodeRegister, 2'b11);
    chk("acc_rdy", CodeReady, 0);
    CodeValid = 1'b0;
    sweep_check(2'b11, 1, 1'b0);
    // single symbol, with Code/CodeValid toggled during the sweep
    Code = 2'b01;
    CodeValid = 1'b1;
    step;
    CodeValid = 1'b0;
    sweep_check(2'b01, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("no_acc_en", ACSEnable, 0);
      chk("no_acc_cnt", SymbolCount, 2);
    end
    // back-to-back with CodeValid held high
    Code = 2'b00;
    CodeValid = 1'b1;
    step;
    last_acc = cyc;
    for (int k = 0; k < 4; k++) begin
      sweep_check(2'(k), 3 + k, 1'b0);
      Code = 2'(k + 1);
      if (k == 3) CodeValid = 1'b0;
      step;
      if (k < 3) begin
        chk("b2b_gap", cyc - last_acc, 66);
        last_acc = cyc;
      end
    end
    chk("b2b_cnt", SymbolCount, 6);
    chk("b2b_idle_en", ACSEnable, 0);
    // reset mid-sweep at segment 30
    Code = 2'b10;
    CodeValid = 1'b1;
    step;
    CodeValid = 1'b0;
    for (int i = 0; i < 30; i++) step;
    chk("mid_seg30", ACSSegment, 30);
    Reset = 1'b1;
    #1;
    chk_reset_vals("mid");
    step;
    Reset = 1'b0;
    step;
    chk("mid_rel_rdy", CodeReady, 1);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("mid_done", SymbolDone, 0);
      chk("mid_cnt", SymbolCount, 0);
    end
`ifdef ACS_SEQ_HOLD_EN
    begin
      int en_n, t, h10, h63;
      en_n = 0;
      h10 = 0;
      h63 = 0;
      Code = 2'b01;
      CodeValid = 1'b1;
      step;
      CodeValid = 1'b0;
      for (t = 1; t < 200 && !SymbolDone; t++) begin
        if (ACSEnable) begin
          chk("hold_seq", ACSSegment, en_n);
          en_n++;
        end
        Hold = (ACSSegment == 10 && h10 < 3) || (ACSSegment == 63 && h63 < 2);
        if (Hold && ACSSegment == 10) h10++;
        if (Hold && ACSSegment == 63) h63++;
        step;
      end
      Hold = 1'b0;
      chk("hold_en_total", en_n, 64);
      chk("hold_done_cyc", t, 70);
      chk("hold_cnt", SymbolCount, 1);
      step;
      chk("hold_rdy", CodeReady, 1);
    end
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
